// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared word width, FSM state encoding and wait counter width.
package mips_mem_pkg;
  localparam int WORD_W = 32;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;
endpackage

// File: rtl/mips_mem_resp_if.sv
// mips_mem_resp_if: request/response bus between the multicycle controller and memory.
interface mips_mem_resp_if;
  import mips_mem_pkg::*;
  logic req, we, ready, busy, err;
  logic [WORD_W-1:0] addr, wdata, rdata;
  modport master (output req, we, addr, wdata, input rdata, ready, busy, err);
  modport slave (input req, we, addr, wdata, output rdata, ready, busy, err);
endinterface

// File: rtl/mips_mem_array.sv
// mips_mem_array: DEPTH x WORD_W storage, synchronous write, registered read.
module mips_mem_array import mips_mem_pkg::*; #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     waddr,
  input  logic [AW-1:0]     raddr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  // Only the read register is reset; the contents survive reset.
  always_ff @(posedge clk or negedge reset)
    if (!reset) rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  assign rdata = rdata_q;
endmodule

// File: rtl/mips_mem_resp.sv
// mips_mem_resp: wait-state memory responder (IDLE/WAIT/RESP) for a multicycle MIPS.
// Define MIPS_MEM_ALIGN_CHECK_EN to flag and suppress misaligned accesses via err.
module mips_mem_resp import mips_mem_pkg::*; #(
  parameter int DEPTH = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  mips_mem_resp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic we_q, mis_q, idle, acc_we, mis, to_resp;
  logic [AW+1:0] addr_q, acc_addr;
  logic [WORD_W-1:0] wdata_q;
  assign idle = state_q == IDLE;
  // The read is launched on the edge entering RESP, which for zero wait states is the accept edge.
  assign acc_we = idle ? bus.we : we_q;
  assign acc_addr = idle ? bus.addr[AW+1:0] : addr_q;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
  assign mis = acc_addr[1:0] != 2'b00;
`else
  assign mis = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (bus.req) begin
        cnt_d = CNT_W'(WAIT_CYCLES);
        if (WAIT_CYCLES == 0) state_d = RESP;
        else state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      mis_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (idle && bus.req) begin
        we_q <= bus.we;
        mis_q <= mis;
        addr_q <= bus.addr[AW+1:0];
        wdata_q <= bus.wdata;
      end
    end
  assign to_resp = (state_d == RESP) && (state_q != RESP);
  mips_mem_array #(.DEPTH(DEPTH)) u_array (
    .clk(clk),
    .reset(reset),
    .we(state_q == RESP && we_q && !mis_q),
    .re(to_resp && !acc_we && !mis),
    .waddr(addr_q[AW+1:2]),
    .raddr(acc_addr[AW+1:2]),
    .wdata(wdata_q),
    .rdata(bus.rdata)
  );
  assign bus.ready = state_q == RESP;
  assign bus.busy = !idle;
  assign bus.err = bus.ready && mis_q;
endmodule

// File: tb/tb_mips_mem_resp.sv
// tb_mips_mem_resp: directed + random checks of two responders (2 and 0 wait states) against a word-array model.
module tb_mips_mem_resp;
  import mips_mem_pkg::*;
  localparam int DEPTH = 256;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  mips_mem_resp_if b0();
  mips_mem_resp_if b1();
  mips_mem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u0 (.clk(clk), .reset(rst_n), .bus(b0));
  mips_mem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u1 (.clk(clk), .reset(rst_n), .bus(b1));

  int passed = 0, failed = 0, total = 0;
  logic [31:0] mem [int];
  logic [31:0] last_rd [2];
  bit known [2];
  int n, rs;
  bit rw;
  logic [31:0] ra, rd;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int key(int sel, logic [31:0] a);
    return sel * DEPTH + int'((a >> 2) % DEPTH);
  endfunction

  task automatic drive(int sel, bit r, bit w, logic [31:0] a, logic [31:0] d);
    if (sel == 1) b1.req = r; else b0.req = r;
    b0.we = w; b1.we = w;
    b0.addr = a; b1.addr = a;
    b0.wdata = d; b1.wdata = d;
  endtask

  task automatic access(int sel, bit w, logic [31:0] a, logic [31:0] d);
    int k;
    int kk = key(sel, a);
    bit mis = ALIGN && (a[1:0] != 2'b00);
    bit chk_rd = known[sel];
    logic [31:0] exp_rd = last_rd[sel];
    if (!w && !mis) begin
      chk_rd = mem.exists(kk);
      if (chk_rd) exp_rd = mem[kk];
    end
    @(negedge clk); drive(sel, 1'b1, w, a, d);
    @(negedge clk); drive(sel, 1'b0, w, a, d);
    k = 1;
    while (!(sel == 1 ? b1.ready : b0.ready) && k < 20) begin
      chk("busy_wait", sel == 1 ? b1.busy : b0.busy, 1);
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), sel == 1 ? 1 : 3);
    chk("busy_rdy", sel == 1 ? b1.busy : b0.busy, 1);
    chk("err", sel == 1 ? b1.err : b0.err, 32'(mis));
    if (chk_rd) chk("rdata", sel == 1 ? b1.rdata : b0.rdata, exp_rd);
    if (w && !mis) mem[kk] = d;
    if (!w && !mis) begin
      known[sel] = chk_rd;
      last_rd[sel] = exp_rd;
    end
    @(negedge clk);
    chk("ready_drop", sel == 1 ? b1.ready : b0.ready, 0);
    chk("busy_drop", sel == 1 ? b1.busy : b0.busy, 0);
  endtask

  initial begin
    b0.req = 1'b0; b1.req = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    known = '{1'b1, 1'b1};
    last_rd = '{32'h0, 32'h0};
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy0", b0.busy, 0);
    chk("rst_ready0", b0.ready, 0);
    chk("rst_err0", b0.err, 0);
    chk("rst_rdata0", b0.rdata, 0);
    chk("rst_busy1", b1.busy, 0);
    chk("rst_rdata1", b1.rdata, 0);
    rst_n = 1'b1;
    access(0, 1'b1, 32'h10, 32'hDEADBEEF);
    access(0, 1'b0, 32'h10, 32'h0);
    access(1, 1'b1, 32'h0, 32'h12345678);
    access(1, 1'b0, 32'h0, 32'h0);
    // A second request while busy must be dropped.
    access(0, 1'b1, 32'h20, 32'h0BADF00D);
    n = 0;
    @(negedge clk); drive(0, 1'b1, 1'b1, 32'h100, 32'h77);
    @(negedge clk); drive(0, 1'b0, 1'b1, 32'h100, 32'h77);
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        chk("busy_ign", b0.busy, 1);
        drive(0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF);
      end else drive(0, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF);
      n += int'(b0.ready);
      @(negedge clk);
    end
    chk("ready_pulses", 32'(n), 1);
    mem[key(0, 32'h100)] = 32'h77;
    access(0, 1'b0, 32'h20, 32'h0);
    access(0, 1'b0, 32'h100, 32'h0);
    // Reset in the WAIT cycle aborts the pending write.
    access(0, 1'b1, 32'h30, 32'h13579BDF);
    @(negedge clk); drive(0, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D);
    @(negedge clk); drive(0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", b0.busy, 0);
    chk("abort_ready", b0.ready, 0);
    chk("abort_rdata0", b0.rdata, 0);
    chk("abort_rdata1", b1.rdata, 0);
    @(negedge clk); rst_n = 1'b1;
    last_rd = '{32'h0, 32'h0};
    known = '{1'b1, 1'b1};
    access(0, 1'b0, 32'h30, 32'h0);
    access(0, 1'b1, 32'h400, 32'hA5A5A5A5);
    access(0, 1'b0, 32'h0, 32'h0);
    access(0, 1'b1, 32'h40, 32'h22222222);
    access(0, 1'b1, 32'h42, 32'h11111111);
    access(0, 1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 40; i++) begin
      rs = int'($urandom_range(1, 0));
      rw = 1'(($urandom_range(1, 0)));
      ra = ($urandom_range(7, 0) << 10) | ($urandom_range(15, 0) << 2) |
           (($urandom_range(3, 0) == 0) ? $urandom_range(3, 0) : 0);
      rd = $urandom;
      access(rs, rw, ra, rd);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mips_mem_resp.md
MIPS_MEM_RESP -- requirements
Module: mips_mem_resp

Interface
REQ-001 SHALL have parameter: DEPTH, 256, number of 32-bit words in the memory array (power of two, at least 4).
REQ-002 SHALL have parameter: WAIT_CYCLES, 2, wait-state cycles inserted before each response (0 to 15).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: req  input  1  one-cycle access request pulse from the multicycle controller.
REQ-006 SHALL have port: we  input  1  write request when 1, read request when 0; sampled with req.
REQ-007 SHALL have port: addr  input  32  byte address; sampled with req.
REQ-008 SHALL have port: wdata  input  32  write data; sampled with req.
REQ-009 SHALL have port: rdata  output  32  read data, registered.
REQ-010 SHALL have port: ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: busy  output  1  high from the cycle after acceptance through the ready cycle.
REQ-012 SHALL have port: err  output  1  misalignment flag, valid with ready.

Function
REQ-013 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-014 SHALL accept req only in IDLE, capturing we, addr and wdata into internal registers; req in WAIT or RESP SHALL be ignored with no side effect.
REQ-015 On acceptance, SHALL move IDLE->WAIT with the counter loaded to WAIT_CYCLES, or IDLE->RESP directly when WAIT_CYCLES=0.
REQ-016 In WAIT, SHALL decrement the counter each cycle and move to RESP in the cycle after the counter reads 1.
REQ-017 In RESP, SHALL assert ready for exactly one cycle and then return to IDLE.
REQ-018 Latency: req sampled at edge N SHALL give ready high during cycle N+WAIT_CYCLES+1; the minimum request spacing is WAIT_CYCLES+2 cycles.
REQ-019 SHALL index the array with word index addr[log2(DEPTH)+1:2]; upper address bits SHALL be ignored, so addresses alias modulo DEPTH words.
REQ-020 SHALL commit a write to the array at the edge ending the RESP cycle; rdata SHALL be unchanged by writes.
REQ-021 SHALL make read data visible on rdata in the RESP cycle and hold it until the next read completes.
REQ-022 A read of a word written by the immediately preceding request SHALL return the new data.
REQ-023 busy SHALL equal (state != IDLE).

Reset
REQ-024 reset low SHALL immediately force state IDLE, counter 0, rdata 0, ready 0, busy 0 and err 0.
REQ-025 reset during WAIT or RESP SHALL abort the access and SHALL NOT commit any pending write.
REQ-026 Array contents SHALL NOT be reset.

Configuration
REQ-027 With macro MIPS_MEM_ALIGN_CHECK_EN defined, an access with addr[1:0] != 0 SHALL complete with normal latency, err=1 during the ready cycle, no array write, and rdata unchanged.
REQ-028 Without MIPS_MEM_ALIGN_CHECK_EN, err SHALL be tied to 0 and addr[1:0] SHALL be ignored.

Structure
REQ-029 Shared package mips_mem_pkg SHALL hold WORD_W=32, the FSM state enumeration (IDLE, WAIT, RESP) and the counter width constant.
REQ-030 The storage SHALL be a sub-module mips_mem_array: synchronous write, registered read, DEPTH x 32, with no reset on contents.
REQ-031 The FSM, counter, capture registers and error logic SHALL reside in mips_mem_resp.

Verification
REQ-032 Write then read, WAIT_CYCLES=2: req/we=1/addr=0x10/wdata=0xDEADBEEF, then read of 0x10 -> ready at N+3 for each access, rdata=0xDEADBEEF.
REQ-033 Zero-wait, WAIT_CYCLES=0: read of 0x0 after a write of 0x12345678 -> ready in cycle N+1, busy high for exactly 1 cycle.
REQ-034 Ignored request: second req pulse while busy=1, with wdata=0xFFFFFFFF to 0x20 -> 0x20 retains its prior value, only one ready pulse.
REQ-035 Reset abort: write 0xCAFEF00D to 0x30, reset low in the WAIT cycle -> busy=0, ready=0 at once; a later read of 0x30 returns the old value.
REQ-036 Aliasing, DEPTH=256: write 0xA5A5A5A5 to 0x400, then read 0x0 -> rdata=0xA5A5A5A5.
REQ-037 Misalignment with MIPS_MEM_ALIGN_CHECK_EN defined: write 0x11111111 to 0x42 -> err=1 with ready; a read of 0x40 returns the prior value and err=0.
